// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and an
// optional tenure cap. Priority rotates past the last owner on every release.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int unsigned      LAST_I     = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               TIMEOUT_EN = (HOLD_MAX != 0);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;

  logic [1:0] win_id;
  logic       owner_req;
  logic       timeout;

  // Scan from the lowest priority upward so the last hit is the highest-priority requester.
  always_comb begin
    win_id = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) win_id = ptr_q + 2'(k);
    end
  end

  assign owner_req = req[gnt_id_q];
  assign timeout   = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d  = GRANT;
          gnt_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (!owner_req || timeout) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          ptr_d     = gnt_id_q + 2'd1;
          // A release with the owner still requesting can only be a timeout.
          preempt_d = owner_req;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign preempt   = preempt_q;

endmodule
